// File: rtl/led_frame_buffer.sv
// Pixel store: processor read/write port plus raster-order scan-out on a valid/ready stream.
// Optional DOUBLE_BUFFER_EN: front/back banks with frame_swap taking effect at frame boundaries.
module led_frame_buffer #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned ROW_LENGTH      = 7,
   parameter int unsigned COLUMN_LENGTH   = 6,
   parameter int unsigned INTERFACE_WIDTH = 3 * DATA_WIDTH
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       enable,
   input  logic [ROW_LENGTH-1:0]      proc_ctrl_row,
   input  logic [COLUMN_LENGTH-1:0]   proc_ctrl_column,
   input  logic                       proc_ctrl_we,
   input  logic [INTERFACE_WIDTH-1:0] proc_ctrl_data_i,
   output logic [INTERFACE_WIDTH-1:0] proc_ctrl_data_o,
   input  logic                       frame_swap,
   output logic                       px_valid,
   input  logic                       px_ready,
   output logic [INTERFACE_WIDTH-1:0] px_data,
   output logic [ROW_LENGTH-1:0]      px_x,
   output logic [COLUMN_LENGTH-1:0]   px_y,
   output logic                       px_sof,
   output logic                       px_eol
);

`ifdef DOUBLE_BUFFER_EN
   localparam int unsigned BANK_BITS = 1;
`else
   localparam int unsigned BANK_BITS = 0;
`endif
   localparam int unsigned ADDR_W    = BANK_BITS + COLUMN_LENGTH + ROW_LENGTH;
   localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_next_state;
   logic [ROW_LENGTH-1:0]      r_x;
   logic [COLUMN_LENGTH-1:0]   r_y;
   logic [ROW_LENGTH-1:0]      w_next_x;
   logic [COLUMN_LENGTH-1:0]   w_next_y;
   logic [ADDR_W-1:0]          w_proc_addr;
   logic [ADDR_W-1:0]          w_scan_addr;
   logic [INTERFACE_WIDTH-1:0] r_mem [MEM_DEPTH];
   logic [INTERFACE_WIDTH-1:0] r_dout;
   logic [INTERFACE_WIDTH-1:0] r_px_data;
   logic                       r_px_valid;
   logic                       r_px_sof;
   logic                       r_px_eol;

`ifdef DOUBLE_BUFFER_EN
   logic r_bank;
   logic r_swap_pending;
   logic w_last;
   logic w_swap_now;

   assign w_proc_addr = {~r_bank, proc_ctrl_column, proc_ctrl_row};
   assign w_scan_addr = {r_bank, r_y, r_x};
   assign w_last      = (r_x == '1) && (r_y == '1);
   // Swap at the accepted bottom-right beat, or straight away while idle.
   assign w_swap_now  = r_swap_pending &&
                        ((r_state == S_IDLE) || ((r_state == S_HOLD) && px_ready && w_last));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_bank         <= 1'b0;
         r_swap_pending <= 1'b0;
      end else begin
         r_bank         <= r_bank ^ w_swap_now;
         r_swap_pending <= w_swap_now ? 1'b0 : (r_swap_pending | frame_swap);
      end
   end
`else
   logic w_unused_swap;

   assign w_unused_swap = frame_swap;
   assign w_proc_addr   = {proc_ctrl_column, proc_ctrl_row};
   assign w_scan_addr   = {r_y, r_x};
`endif

   // Pixel storage; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (proc_ctrl_we) begin
         r_mem[w_proc_addr] <= proc_ctrl_data_i;
      end
   end

   // Scan state register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and raster counter update.
   always_comb begin
      w_next_state = r_state;
      w_next_x     = r_x;
      w_next_y     = r_y;
      case (r_state)
         S_IDLE: begin
            w_next_x = '0;
            w_next_y = '0;
            if (enable) begin
               w_next_state = S_READ;
            end
         end
         S_READ: begin
            w_next_state = S_HOLD;
         end
         S_HOLD: begin
            if (px_ready) begin
               if (enable) begin
                  w_next_state = S_READ;
                  w_next_x     = r_x + ROW_LENGTH'(1);
                  if (r_x == '1) begin
                     w_next_y = r_y + COLUMN_LENGTH'(1);
                  end
               end else begin
                  w_next_state = S_IDLE;
                  w_next_x     = '0;
                  w_next_y     = '0;
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_x     = '0;
            w_next_y     = '0;
         end
      endcase
   end

   // Readback and scan output registers; memory reads here see pre-write contents.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_x        <= '0;
         r_y        <= '0;
         r_dout     <= '0;
         r_px_data  <= '0;
         r_px_valid <= 1'b0;
         r_px_sof   <= 1'b0;
         r_px_eol   <= 1'b0;
      end else begin
         r_x        <= w_next_x;
         r_y        <= w_next_y;
         r_px_valid <= (w_next_state == S_HOLD);
         r_dout     <= proc_ctrl_we ? proc_ctrl_data_i : r_mem[w_proc_addr];
         if (r_state == S_READ) begin
            r_px_data <= r_mem[w_scan_addr];
            r_px_sof  <= (r_x == '0) && (r_y == '0);
            r_px_eol  <= (r_x == '1);
         end
      end
   end

   assign proc_ctrl_data_o = r_dout;
   assign px_valid         = r_px_valid;
   assign px_data          = r_px_data;
   assign px_x             = r_x;
   assign px_y             = r_y;
   assign px_sof           = r_px_sof;
   assign px_eol           = r_px_eol;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Randomised bench for led_frame_buffer with an in-bench reference model of pixel store and beat stream.
// Build with +define+DOUBLE_BUFFER_EN to exercise the banked configuration.
module tb_led_frame_buffer;

`ifdef DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif
   localparam int NPIX = 8192;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        en;
   logic [6:0]  row;
   logic [5:0]  col;
   logic        we;
   logic [23:0] din;
   logic [23:0] dout;
   logic        swap;
   logic        pv;
   logic        ready;
   logic [23:0] pdata;
   logic [6:0]  px;
   logic [5:0]  py;
   logic        psof;
   logic        peol;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   logic [23:0] m_mem [0:1][0:NPIX-1];
   int          m_phase;          // 0 idle, 1 fetch cycle, 2 beat presented
   int          m_x, m_y;
   bit          m_bank, m_pending;
   logic [23:0] e_dout, e_data;
   int          e_bx, e_by;
   bit          e_valid, e_sof, e_eol;

   led_frame_buffer dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .enable           (en),
      .proc_ctrl_row    (row),
      .proc_ctrl_column (col),
      .proc_ctrl_we     (we),
      .proc_ctrl_data_i (din),
      .proc_ctrl_data_o (dout),
      .frame_swap       (swap),
      .px_valid         (pv),
      .px_ready         (ready),
      .px_data          (pdata),
      .px_x             (px),
      .px_y             (py),
      .px_sof           (psof),
      .px_eol           (peol)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model step for the edge just taken, then compare every output that is meaningful.
   always @(posedge clk) begin : model_cmp
      int  pa;
      bit  pb, sb, was_idle, hs, last;
      #1;
      if (!n_rst) begin
         m_phase = 0; m_x = 0; m_y = 0; m_bank = 0; m_pending = 0;
         e_valid = 0; e_dout = '0;
      end else begin
         pa       = int'(col) * 128 + int'(row);
         pb       = DB ? ~m_bank : 1'b0;
         sb       = DB ? m_bank : 1'b0;
         was_idle = (m_phase == 0);
         hs       = 0;
         last     = 0;
         e_dout   = we ? din : m_mem[pb][pa];
         if (m_phase == 2) begin
            if (ready) begin
               hs      = 1;
               last    = (m_x == 127) && (m_y == 63);
               e_valid = 0;
               if (en) begin
                  m_x = (m_x + 1) % 128;
                  if (m_x == 0) m_y = (m_y + 1) % 64;
                  m_phase = 1;
               end else begin
                  m_x = 0; m_y = 0; m_phase = 0;
               end
            end
         end else if (m_phase == 1) begin
            e_data  = m_mem[sb][m_y * 128 + m_x];
            e_sof   = (m_x == 0) && (m_y == 0);
            e_eol   = (m_x == 127);
            e_bx    = m_x;
            e_by    = m_y;
            e_valid = 1;
            m_phase = 2;
         end else if (en) begin
            m_phase = 1;
         end
         if (DB) begin
            if (m_pending && (was_idle || (hs && last))) begin
               m_bank = ~m_bank; m_pending = 0;
            end else if (swap) begin
               m_pending = 1;
            end
         end
         if (we) m_mem[pb][pa] = din;

         check("px_valid", 32'(pv), 32'(e_valid));
         check("data_o", 32'(dout), 32'(e_dout));
         if (e_valid) begin
            check("px_data", 32'(pdata), 32'(e_data));
            check("px_x", 32'(px), 32'(e_bx));
            check("px_y", 32'(py), 32'(e_by));
            check("px_sof", 32'(psof), 32'(e_sof));
            check("px_eol", 32'(peol), 32'(e_eol));
         end
      end
   end

   task automatic rand_proc(input bit allow55);
      we  = ($urandom % 4) == 0;
      row = 7'($urandom);
      col = 6'($urandom);
      din = 24'($urandom);
      if (!allow55 && row == 7'd5 && col == 6'd5) row = 7'd6;
   endtask

   task automatic wait_valid(input int max, input string tag);
      int n = 0;
      while (!pv && n < max) begin
         @(negedge clk);
         n++;
      end
      if (!pv) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout actual=0 expected=1", tag);
      end
   endtask

   task automatic fill_all();
      for (int a = 0; a < NPIX; a++) begin
         row = a[6:0];
         col = a[12:7];
         we  = 1'b1;
         din = (a == 5 * 128 + 5) ? 24'h0 : 24'($urandom);
         @(negedge clk);
      end
      we = 1'b0;
   endtask

   initial begin
      int beats, guard;
      bit do55;
      n_rst = 1'b0; en = 1'b0; row = '0; col = '0; we = 1'b0; din = '0;
      swap = 1'b0; ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(pv), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_x", 32'(px), 32'd0);
      check("rst_y", 32'(py), 32'd0);
      n_rst = 1'b1;
      @(negedge clk);

      // Preload every pixel so the model knows the whole store.
      fill_all();
`ifdef DOUBLE_BUFFER_EN
      swap = 1'b1;
      @(negedge clk);
      swap = 1'b0;
      @(negedge clk);
      fill_all();
`endif

      // Processor write then readback of (3,2).
      row = 7'd3; col = 6'd2; we = 1'b1; din = 24'h0A0B0C;
      @(negedge clk);
      check("wr_first_dout", 32'(dout), 32'h0A0B0C);
      we = 1'b0;
      @(negedge clk);
      check("rd_dout", 32'(dout), 32'h0A0B0C);
      row = 7'd4;
      @(negedge clk);

      // Continuous stream with ready held high across a full frame wrap.
      en = 1'b1; ready = 1'b1; beats = 0; guard = 0; do55 = 0;
      while (beats < NPIX + 700 && guard < 20000) begin
         @(negedge clk);
         guard++;
         rand_proc(1'b0);
         if (do55) begin
            we = 1'b1; row = 7'd5; col = 6'd5; din = 24'hFFFFFF; do55 = 0;
         end
         if (pv) begin
            if (beats == 0) begin
               check("b0_sof", 32'(psof), 32'd1);
               check("b0_x", 32'(px), 32'd0);
               check("b0_y", 32'(py), 32'd0);
            end
            if (beats == 127) begin
               check("b127_eol", 32'(peol), 32'd1);
               check("b127_x", 32'(px), 32'd127);
            end
            if (beats == 128) begin
               check("b128_y", 32'(py), 32'd1);
               check("b128_eol", 32'(peol), 32'd0);
            end
            if (beats == 645) check("rdfirst_old", 32'(pdata), 32'd0);
            if (beats == NPIX) begin
               check("wrap_sof", 32'(psof), 32'd1);
               check("wrap_x", 32'(px), 32'd0);
               check("wrap_y", 32'(py), 32'd0);
            end
`ifndef DOUBLE_BUFFER_EN
            if (beats == NPIX + 645) check("rdfirst_new", 32'(pdata), 32'hFFFFFF);
`endif
            if (beats == 644) do55 = 1;
            beats++;
         end
      end
      if (guard >= 20000) check("stream_timeout", 32'(beats), 32'(NPIX + 700));
      we = 1'b0;

      // Random backpressure for a while.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         ready = 1'($urandom);
         rand_proc(1'b1);
      end

      // Five-cycle stall, then drop enable: one more beat only.
      we = 1'b0; ready = 1'b0;
      wait_valid(10, "stall_wait");
      begin
         int cx, cy;
         logic [23:0] cd;
         cx = e_bx; cy = e_by; cd = e_data;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(pv), 32'd1);
            check("stall_x", 32'(px), 32'(cx));
            check("stall_y", 32'(py), 32'(cy));
            check("stall_data", 32'(pdata), 32'(cd));
         end
      end
      en = 1'b0; ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("drop_idle", 32'(pv), 32'd0);
      end
      en = 1'b1; ready = 1'b0;
      wait_valid(10, "restart_wait");
      check("restart_sof", 32'(psof), 32'd1);
      check("restart_x", 32'(px), 32'd0);
      check("restart_y", 32'(py), 32'd0);

      // Fully random phase, including swap pulses and enable drops.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         en    = ($urandom % 16) != 0;
         ready = 1'($urandom);
         swap  = ($urandom % 64) == 0;
         rand_proc(1'b1);
      end
      swap = 1'b0; we = 1'b0;

      // Asynchronous reset while a beat is held.
      en = 1'b1; ready = 1'b0;
      wait_valid(20, "arst_wait");
      n_rst = 1'b0;
      #1;
      check("arst_valid", 32'(pv), 32'd0);
      check("arst_dout", 32'(dout), 32'd0);
      check("arst_x", 32'(px), 32'd0);
      check("arst_y", 32'(py), 32'd0);
      check("arst_sof", 32'(psof), 32'd0);
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;

      // Fresh stream after reset; with banks, a mid-frame swap shows up next frame.
      ready = 1'b1; beats = 0; guard = 0;
      while (beats < (DB ? NPIX + 20 : 40) && guard < 20000) begin
         @(negedge clk);
         guard++;
         we = 1'b0; swap = 1'b0;
         if (pv) begin
            if (beats == 0) check("post_rst_sof", 32'(psof), 32'd1);
`ifdef DOUBLE_BUFFER_EN
            if (beats == 300) begin
               we = 1'b1; row = 7'd10; col = 6'd0; din = 24'h123456; swap = 1'b1;
            end
            if (beats == NPIX + 10) check("db_swapped", 32'(pdata), 32'h123456);
`endif
            beats++;
         end
      end
      if (guard >= 20000) check("post_rst_timeout", 32'(beats), 32'd0);
      we = 1'b0; swap = 1'b0; en = 1'b0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
